// File: rtl/and_tree_pipe_if.sv
// and_tree_pipe_if: sample/result bundle for the pipelined reduction tree.
// master drives samples, slave is the tree.
interface and_tree_pipe_if #(
  parameter int N_IN  = 8,
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic                        in_valid;
  logic [1:0]                  mode;
  logic [N_IN*WIDTH-1:0]       din;
  logic                        cnt_clr;
  logic                        out_valid;
  logic [WIDTH-1:0]            dout;
  logic [(N_IN/2)*WIDTH-1:0]   lvl1_out;
  logic                        lvl1_valid;
  logic [CNT_W-1:0]            ones_cnt;

  modport master (
    output in_valid, mode, din, cnt_clr,
    input  out_valid, dout, lvl1_out, lvl1_valid, ones_cnt
  );

  modport slave (
    input  in_valid, mode, din, cnt_clr,
    output out_valid, dout, lvl1_out, lvl1_valid, ones_cnt
  );
endinterface

// File: rtl/and_tree_pipe.sv
// and_tree_pipe: balanced, one-register-per-level reduction tree
// (AND/OR/XOR/NAND) with a saturating all-ones result counter.
module and_tree_pipe #(
  parameter int N_IN  = 8,
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  and_tree_pipe_if.slave      bus
);
  localparam int L = $clog2(N_IN);

  if ((N_IN < 2) || ((1 << L) != N_IN)) begin : g_bad_n
    $error("and_tree_pipe: N_IN must be a power of two >= 2");
  end

  // Heap layout: node 1 is the root, node k feeds from 2k and 2k+1.
  // Indices N_IN..2*N_IN-1 are the raw inputs.
  logic [WIDTH-1:0] r_node [1:N_IN-1];
  logic [WIDTH-1:0] w_node [1:2*N_IN-1];
  logic             r_vld  [1:L];
  logic [1:0]       r_mode [1:L];
  logic             w_vld  [0:L-1];
  logic [1:0]       w_mode [0:L-1];
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_dout;
  logic             w_ones;

  // NAND reduces as AND; only the final result is inverted.
  function automatic logic [WIDTH-1:0] f_op(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    case (m)
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return a & b;
    endcase
  endfunction

  assign w_vld[0]  = bus.in_valid;
  assign w_mode[0] = bus.mode;

  for (genvar i = 1; i < L; i++) begin : g_src
    assign w_vld[i]  = r_vld[i];
    assign w_mode[i] = r_mode[i];
  end

  for (genvar k = 1; k < N_IN; k++) begin : g_nsrc
    assign w_node[k] = r_node[k];
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_din
    assign w_node[N_IN+k] = bus.din[k*WIDTH +: WIDTH];
  end

  for (genvar lv = 1; lv <= L; lv++) begin : g_lvl
    // Valid always advances; mode is only clocked with valid data.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld[lv]  <= 1'b0;
        r_mode[lv] <= 2'b00;
      end else begin
        r_vld[lv] <= w_vld[lv-1];
        if (w_vld[lv-1]) r_mode[lv] <= w_mode[lv-1];
      end
    end
  end

  for (genvar k = 1; k < N_IN; k++) begin : g_node
    localparam int LV = L - $clog2(k + 1) + 1;
    // Combine the two children when the feeding level is valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_node[k] <= '0;
      end else if (w_vld[LV-1]) begin
        r_node[k] <= f_op(w_mode[LV-1], w_node[2*k], w_node[2*k+1]);
      end
    end
  end

  assign w_dout = (r_mode[L] == 2'b11) ? ~r_node[1] : r_node[1];
  assign w_ones = r_vld[L] && (&w_dout);

  // Saturating count of all-ones results; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      r_cnt <= '0;
    end else if (w_ones && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar j = 0; j < N_IN/2; j++) begin : g_l1
    assign bus.lvl1_out[j*WIDTH +: WIDTH] = r_node[N_IN/2+j];
  end

  assign bus.lvl1_valid = r_vld[1];
  assign bus.out_valid  = r_vld[L];
  assign bus.dout       = w_dout;
  assign bus.ones_cnt   = r_cnt;
endmodule

// File: tb/tb_and_tree_pipe.sv
// tb_and_tree_pipe: scoreboard bench for and_tree_pipe with a flat
// reduction reference model, two parameter sets.
module tb_and_tree_pipe;
  localparam int N0 = 8, W0 = 4, C0 = 2,  L0 = 3;
  localparam int N1 = 4, W1 = 1, C1 = 16, L1 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  and_tree_pipe_if #(.N_IN(N0), .WIDTH(W0), .CNT_W(C0)) b0();
  and_tree_pipe_if #(.N_IN(N1), .WIDTH(W1), .CNT_W(C1)) b1();

  and_tree_pipe #(.N_IN(N0), .WIDTH(W0), .CNT_W(C0)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  and_tree_pipe #(.N_IN(N1), .WIDTH(W1), .CNT_W(C1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  typedef struct {
    int          due;
    logic [63:0] v;
  } exp_t;

  exp_t q0d[$], q0l[$], q1d[$], q1l[$];
  exp_t e0, e1;
  int n_chk = 0, n_pass = 0, cyc = 0;
  bit armed = 0;
  bit ones0, ones1;
  logic [63:0] last0d = 0, last0l = 0, last1d = 0, last1l = 0;
  longint m0 = 0, m1 = 0;
  localparam logic [63:0] MSK0 = (64'd1 << W0) - 64'd1;
  localparam logic [63:0] MSK1 = (64'd1 << W1) - 64'd1;
  localparam longint MAX0 = (64'd1 << C0) - 1;
  localparam longint MAX1 = (64'd1 << C1) - 1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_red(
    input int n, input int w, input logic [1:0] md, input logic [63:0] d
  );
    logic [63:0] msk, r, x;
    msk = (64'd1 << w) - 64'd1;
    r = d & msk;
    for (int k = 1; k < n; k++) begin
      x = (d >> (k * w)) & msk;
      if (md == 2'b01)      r = r | x;
      else if (md == 2'b10) r = r ^ x;
      else                  r = r & x;
    end
    if (md == 2'b11) r = ~r & msk;
    return r;
  endfunction

  function automatic logic [63:0] ref_l1(
    input int n, input int w, input logic [1:0] md, input logic [63:0] d
  );
    logic [63:0] r;
    logic [1:0]  pm;
    pm = (md == 2'b11) ? 2'b00 : md;
    r = '0;
    for (int j = 0; j < n / 2; j++)
      r = r | (ref_red(2, w, pm, d >> (2 * j * w)) << (j * w));
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  task automatic issue0(input logic v, input logic [1:0] md,
                        input logic [63:0] d, input logic clr,
                        input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    b0.in_valid = v;
    b0.mode = md;
    b0.din = d[N0*W0-1:0];
    b0.cnt_clr = clr;
    if (v && !r) begin
      e.due = cyc + L0; e.v = ref_red(N0, W0, md, d);
      q0d.push_back(e);
      e.due = cyc + 1;  e.v = ref_l1(N0, W0, md, d);
      q0l.push_back(e);
    end
  endtask

  task automatic issue1(input logic v, input logic [1:0] md,
                        input logic [63:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    b1.in_valid = v;
    b1.mode = md;
    b1.din = d[N1*W1-1:0];
    b1.cnt_clr = 1'b0;
    if (v && !rst) begin
      e.due = cyc + L1; e.v = ref_red(N1, W1, md, d);
      q1d.push_back(e);
      e.due = cyc + 1;  e.v = ref_l1(N1, W1, md, d);
      q1l.push_back(e);
    end
  endtask

  task automatic reset_checks(input string tag);
    @(negedge clk);
    check({tag, "_out_valid"}, b0.out_valid, 0);
    check({tag, "_dout"}, b0.dout, 0);
    check({tag, "_lvl1_valid"}, b0.lvl1_valid, 0);
    check({tag, "_lvl1_out"}, b0.lvl1_out, 0);
    check({tag, "_ones_cnt"}, b0.ones_cnt, 0);
    check({tag, "_u1_out_valid"}, b1.out_valid, 0);
  endtask

  always @(negedge clk) if (armed) begin
    ones0 = 0;
    if (b0.out_valid) begin
      if (q0d.size() == 0) check("u0_spurious_valid", 1, 0);
      else begin
        e0 = q0d.pop_front();
        check("u0_latency", cyc, e0.due);
        check("u0_dout", b0.dout, e0.v);
        last0d = e0.v;
        ones0 = (e0.v == MSK0);
      end
    end else begin
      check("u0_dout_hold", b0.dout, last0d);
      if (q0d.size() > 0 && q0d[0].due <= cyc) begin
        check("u0_missing_valid", 0, 1);
        q0d.delete(0);
      end
    end
    if (b0.lvl1_valid) begin
      if (q0l.size() == 0) check("u0_spurious_l1", 1, 0);
      else begin
        e0 = q0l.pop_front();
        check("u0_l1_latency", cyc, e0.due);
        check("u0_lvl1_out", b0.lvl1_out, e0.v);
        last0l = e0.v;
      end
    end else begin
      check("u0_l1_hold", b0.lvl1_out, last0l);
      if (q0l.size() > 0 && q0l[0].due <= cyc) begin
        check("u0_missing_l1", 0, 1);
        q0l.delete(0);
      end
    end
    check("u0_ones_cnt", b0.ones_cnt, m0);
    if (rst) begin
      q0d.delete(); q0l.delete();
      last0d = 0; last0l = 0; m0 = 0;
    end else if (b0.cnt_clr) m0 = 0;
    else if (ones0 && m0 < MAX0) m0++;
  end

  always @(negedge clk) if (armed) begin
    ones1 = 0;
    if (b1.out_valid) begin
      if (q1d.size() == 0) check("u1_spurious_valid", 1, 0);
      else begin
        e1 = q1d.pop_front();
        check("u1_latency", cyc, e1.due);
        check("u1_dout", b1.dout, e1.v);
        last1d = e1.v;
        ones1 = (e1.v == MSK1);
      end
    end else begin
      check("u1_dout_hold", b1.dout, last1d);
      if (q1d.size() > 0 && q1d[0].due <= cyc) begin
        check("u1_missing_valid", 0, 1);
        q1d.delete(0);
      end
    end
    if (b1.lvl1_valid) begin
      if (q1l.size() == 0) check("u1_spurious_l1", 1, 0);
      else begin
        e1 = q1l.pop_front();
        check("u1_l1_latency", cyc, e1.due);
        check("u1_lvl1_out", b1.lvl1_out, e1.v);
        last1l = e1.v;
      end
    end else begin
      check("u1_l1_hold", b1.lvl1_out, last1l);
      if (q1l.size() > 0 && q1l[0].due <= cyc) begin
        check("u1_missing_l1", 0, 1);
        q1l.delete(0);
      end
    end
    check("u1_ones_cnt", b1.ones_cnt, m1);
    if (rst) begin
      q1d.delete(); q1l.delete();
      last1d = 0; last1l = 0; m1 = 0;
    end else if (b1.cnt_clr) m1 = 0;
    else if (ones1 && m1 < MAX1) m1++;
  end

  initial begin
    logic [63:0] ones;
    logic [63:0] rd;
    int md;
    ones = 64'hFFFF_FFFF;
    b0.in_valid = 0; b0.mode = 0; b0.din = 0; b0.cnt_clr = 0;
    b1.in_valid = 0; b1.mode = 0; b1.din = 0; b1.cnt_clr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    armed = 1;
    reset_checks("por");

    issue0(1, 2'b00, ones, 0, 0);
    issue0(1, 2'b00, ones - 1, 0, 0);
    repeat (5) issue0(0, 0, 0, 0, 0);

    for (int m = 0; m < 4; m++)
      for (int d = 0; d < 16; d++) begin
        md = m;
        issue1(1, md[1:0], 64'(d));
      end
    repeat (4) issue1(0, 0, 0);

    issue0(1, 2'b00, ones, 0, 0);
    issue0(1, 2'b10, ones, 0, 0);
    issue0(1, 2'b11, ones, 0, 0);
    repeat (4) issue0(0, 0, 0, 0, 0);

    issue0(1, 2'b00, {$urandom, $urandom}, 0, 0);
    issue0(0, 2'b00, 0, 0, 0);
    issue0(1, 2'b01, {$urandom, $urandom}, 0, 0);
    repeat (4) issue0(0, 0, 0, 0, 0);

    issue0(0, 0, 0, 1, 0);
    repeat (5) issue0(1, 2'b00, ones, 0, 0);
    repeat (5) issue0(0, 0, 0, 0, 0);
    issue0(1, 2'b00, ones, 0, 0);
    repeat (2) issue0(0, 0, 0, 0, 0);
    issue0(0, 0, 0, 1, 0);
    repeat (3) issue0(0, 0, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      rd = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rd = ones;
      md = $urandom_range(0, 3);
      issue0(1'($urandom_range(0, 3) != 0), md[1:0], rd,
             1'($urandom_range(0, 15) == 0), 0);
    end
    repeat (4) issue0(0, 0, 0, 0, 0);
    for (int i = 0; i < 150; i++) begin
      md = $urandom_range(0, 3);
      issue1(1'($urandom_range(0, 3) != 0), md[1:0], 64'($urandom));
    end
    repeat (4) issue1(0, 0, 0);

    issue0(1, 2'b00, ones, 0, 0);
    issue0(1, 2'b01, {$urandom, $urandom}, 0, 0);
    issue0(1, 2'b10, {$urandom, $urandom}, 0, 1);
    issue0(0, 0, 0, 0, 0);
    reset_checks("mid");
    issue0(1, 2'b01, {$urandom, $urandom}, 0, 0);
    repeat (6) issue0(0, 0, 0, 0, 0);

    @(negedge clk);
    check("u0_q_empty", 64'(q0d.size() + q0l.size()), 0);
    check("u1_q_empty", 64'(q1d.size() + q1l.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
